// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm bank: channel state encoding,
// BCD time field layout and the BCD time validity check.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ch_state_t;

  // Field positions inside a 24-bit BCD HH:MM:SS word
  localparam int HH_MSB = 23;
  localparam int HH_LSB = 16;
  localparam int MM_MSB = 15;
  localparam int MM_LSB = 8;
  localparam int SS_MSB = 7;
  localparam int SS_LSB = 0;

  // Largest legal BCD hour and minute/second bytes
  localparam logic [7:0] MAX_HH = 8'h23;
  localparam logic [7:0] MAX_MS = 8'h59;

  // True when every digit is a decimal digit and each field is in range.
  // A byte with a decimal low digit can be range-checked as plain binary.
  function automatic logic bcd_time_valid(input logic [23:0] t);
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    hh = t[HH_MSB:HH_LSB];
    mm = t[MM_MSB:MM_LSB];
    ss = t[SS_MSB:SS_LSB];
    return (hh[3:0] <= 4'h9) && (hh <= MAX_HH) &&
           (mm[3:0] <= 4'h9) && (mm <= MAX_MS) &&
           (ss[3:0] <= 4'h9) && (ss <= MAX_MS);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, ring/snooze state machine,
// ring and snooze second counters and the per-event snooze count.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sec_tick,
  input  logic [23:0] cur_time,
  input  logic        wr_hit,
  input  logic [23:0] wr_data,
  input  logic        en,
  input  logic        dismiss,
  input  logic        snooze,
  output logic        ring_next,
  output logic        ringing
);

  // Counters are wide enough to hold their limit, so they never wrap early
  localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS + 1)   : 1;
  localparam int WW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS + 1) : 1;
  localparam int SW = (SNOOZE_MAX  > 0) ? $clog2(SNOOZE_MAX + 1)  : 1;

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SNOOZE_SECS - 1);
  localparam logic [SW-1:0] SNZ_LIMIT = SW'(SNOOZE_MAX);

  ch_state_t     state_reg,    state_next;
  logic [23:0]   time_reg,     time_next;
  logic [RW-1:0] ring_cnt_reg, ring_cnt_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [SW-1:0] snz_cnt_reg,  snz_cnt_next;

  // Next-state logic: a valid write beats everything, then dismiss/disable,
  // then the normal ring/snooze flow (snooze beats a same-cycle second tick).
  always_comb begin
    state_next    = state_reg;
    time_next     = time_reg;
    ring_cnt_next = ring_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    if (wr_hit) begin
      time_next    = wr_data;
      state_next   = ST_IDLE;
      snz_cnt_next = '0;
    end else if (dismiss || !en) begin
      state_next   = ST_IDLE;
      snz_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sec_tick && (cur_time == time_reg)) begin
            state_next    = ST_RING;
            ring_cnt_next = '0;
          end
        end
        ST_RING: begin
          if (snooze) begin
            if (snz_cnt_reg < SNZ_LIMIT) begin
              state_next    = ST_SNOOZE;
              snz_cnt_next  = snz_cnt_reg + SW'(1);
              wait_cnt_next = '0;
            end else begin
              state_next   = ST_IDLE;
              snz_cnt_next = '0;
            end
          end else if (sec_tick) begin
            if (ring_cnt_reg == RING_LAST) begin
              state_next   = ST_IDLE;
              snz_cnt_next = '0;
            end else begin
              ring_cnt_next = ring_cnt_reg + RW'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (sec_tick) begin
            if (wait_cnt_reg == WAIT_LAST) begin
              state_next    = ST_RING;
              ring_cnt_next = '0;
            end else begin
              wait_cnt_next = wait_cnt_reg + WW'(1);
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, alarm time and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      time_reg     <= '0;
      ring_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      time_reg     <= time_next;
      ring_cnt_reg <= ring_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      snz_cnt_reg  <= snz_cnt_next;
    end
  end

  assign ring_next = (state_next == ST_RING);
  assign ringing   = (state_reg == ST_RING);

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm bank: write decode with validity check, NUM_CH alarm
// channels, lowest-index ringing encoder and the LED blinker.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int LED_W       = 2,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_tick,
  input  logic [23:0]       cur_time,
  input  logic              alarm_wr,
  input  logic [CH_W-1:0]   alarm_sel,
  input  logic [23:0]       alarm_wdata,
  input  logic [NUM_CH-1:0] alarm_en,
  input  logic              dismiss,
  input  logic              snooze,
  input  logic              blink_tick,
  output logic [LED_W-1:0]  led,
  output logic [NUM_CH-1:0] ringing,
  output logic [CH_W-1:0]   active_ch,
  output logic              wr_err
);

  logic              sel_ok;
  logic              wr_ok;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] ring_next;
  logic [CH_W-1:0]   active_next;
  logic              multi_next;
  logic              phase_next;
  logic [LED_W-1:0]  led_next;

  logic              phase_reg;
  logic [LED_W-1:0]  led_reg;
  logic [CH_W-1:0]   active_reg;
  logic              wr_err_reg;

  assign sel_ok = (32'(alarm_sel) < NUM_CH);
  assign wr_ok  = alarm_wr && sel_ok && bcd_time_valid(alarm_wdata);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_hit[gi] = wr_ok && (alarm_sel == CH_W'(gi));

      alarm_channel #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .SNOOZE_MAX  (SNOOZE_MAX)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_tick  (sec_tick),
        .cur_time  (cur_time),
        .wr_hit    (wr_hit[gi]),
        .wr_data   (alarm_wdata),
        .en        (alarm_en[gi]),
        .dismiss   (dismiss),
        .snooze    (snooze),
        .ring_next (ring_next[gi]),
        .ringing   (ringing[gi])
      );
    end
  endgenerate

  // Lowest-index ringer, blink phase and LED pattern, all computed from the
  // channels' next state so they line up with the registered ringing flags.
  always_comb begin
    active_next = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ring_next[i]) active_next = CH_W'(i);
    end
    multi_next = ((ring_next & (ring_next - NUM_CH'(1))) != '0);

    phase_next = phase_reg;
    if (ring_next == '0) phase_next = 1'b0;
    else if (blink_tick) phase_next = ~phase_reg;

    led_next = '0;
    if (ring_next != '0) begin
      if ((LED_W == 1) || !multi_next) begin
        led_next = {LED_W{phase_next}};
      end else begin
        for (int b = 0; b < LED_W; b++) begin
          led_next[b] = ((b % 2) == 1) ? ~phase_next : phase_next;
        end
      end
    end
  end

  // Output and blink-phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg  <= 1'b0;
      led_reg    <= '0;
      active_reg <= '0;
      wr_err_reg <= 1'b0;
    end else begin
      phase_reg  <= phase_next;
      led_reg    <= led_next;
      active_reg <= active_next;
      wr_err_reg <= alarm_wr && !wr_ok;
    end
  end

  assign led       = led_reg;
  assign active_ch = active_reg;
  assign wr_err    = wr_err_reg;

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised multi-channel successor to the single alarm in the clock design.
- Holds NUM_CH programmable BCD alarm times (HH:MM:SS, 24-bit).
- Compares each enabled alarm against the running time on every seconds tick.
- Runs a per-channel ring/snooze state machine and drives the LED blink output. Sits between the timekeeping counter and the board LEDs/buttons.

Parameters:
- NUM_CH, 4, number of independent alarm channels (1..8)
- CH_W, 2, width of channel select, ceil(log2(NUM_CH)), min 1
- LED_W, 2, width of the LED output bus
- RING_SECS, 60, seconds a channel rings before auto-timeout
- SNOOZE_SECS, 300, seconds a snoozed channel waits before re-ringing
- SNOOZE_MAX, 3, snoozes allowed per alarm event; further snooze acts as dismiss

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse, cur_time has just advanced by one second
- cur_time  in  24  current time, BCD HH:MM:SS
- alarm_wr  in  1  write strobe for alarm time
- alarm_sel  in  CH_W  channel addressed by alarm_wr
- alarm_wdata  in  24  BCD alarm time to write
- alarm_en  in  NUM_CH  per-channel enable, level
- dismiss  in  1  one-cycle pulse (debounced upstream), stops all ringing/snoozed channels
- snooze  in  1  one-cycle pulse, snoozes all ringing channels
- blink_tick  in  1  one-cycle pulse setting LED toggle rate
- led  out  LED_W  blink output
- ringing  out  NUM_CH  per-channel ringing flag
- active_ch  out  CH_W  lowest-index ringing channel, 0 when none
- wr_err  out  1  one-cycle pulse, rejected alarm write

Behaviour:
- Reset values: all alarm times 00:00:00, all channels IDLE, led=0, ringing=0, active_ch=0, wr_err=0, blink phase 0, snooze counts 0, second counters 0.
- Write path:
  - alarm_wr with valid BCD (HH 00-23, MM 00-59, SS 00-59) stores alarm_wdata into channel alarm_sel at the next edge.
  - Invalid BCD, or alarm_sel >= NUM_CH: storage unchanged, wr_err=1 for one cycle.
  - A valid write to a channel not in IDLE forces it to IDLE and clears its snooze count.
- Per-channel FSM (states IDLE, RING, SNOOZE):
  - IDLE->RING: sec_tick & alarm_en[i] & cur_time==alarm_time[i]. Exact equality only; no window. Ring second counter loads 0.
  - RING: counter increments on each sec_tick. On reaching RING_SECS -> IDLE (timeout) and snooze count cleared.
  - RING->SNOOZE: snooze pulse while snooze count < SNOOZE_MAX. Count increments; wait counter loads 0.
  - RING with snooze count == SNOOZE_MAX: snooze acts as dismiss -> IDLE.
  - SNOOZE: wait counter increments on sec_tick. On reaching SNOOZE_SECS -> RING with ring counter reloaded 0.
  - Any state -> IDLE on dismiss, or on alarm_en[i]=0 (next edge). Snooze count cleared.
  - Time matches during RING/SNOOZE are ignored.
- Simultaneous events:
  - dismiss and snooze in the same cycle: dismiss wins.
  - Valid write to the same channel in the same cycle as its match: write wins, channel stays IDLE.
  - Several channels matching the same second all enter RING.
- Outputs (all registered, one cycle after the state change):
  - ringing[i] = (state==RING).
  - active_ch = lowest i with ringing[i].
  - led:
    - Blink phase toggles on blink_tick while |ringing; forced 0 when none ringing.
    - led = {LED_W{phase}} for a single ringer; led = {LED_W/2{2'b10^{phase,phase}}} alternating pattern when two or more ring. LED_W even; LED_W=1 uses the single-ringer form.
- Counter widths are sized from RING_SECS/SNOOZE_SECS via $clog2, and must not wrap before the limit.
- Reset asserted mid-ring: immediate return to reset values, stored alarm times included.

Decomposition:
- Shared package alarm_pkg:
  - state encoding typedef (IDLE/RING/SNOOZE)
  - BCD time field positions
  - bcd_time_valid() function
  - max legal BCD constants (8'h23, 8'h59)
- One sub-module alarm_channel: one FSM + alarm-time register + counters, instantiated NUM_CH times by generate.
- The top holds the write decode, priority encoder, and LED blinker.

Test Plan:
- Write ch1=07:30:00, en=4'b0010, step cur_time 07:29:59->07:30:00 with sec_tick -> ringing=4'b0010, active_ch=1 one cycle later; after 60 more sec_ticks ringing=0.
- Write alarm_wdata=24'h246000 -> wr_err pulse, stored time unchanged (readback via match at old time still rings).
- Ringing ch1, snooze -> ringing=0; after 300 sec_ticks ringing=4'b0010 again. Fourth snooze (SNOOZE_MAX=3 used) -> IDLE, no re-ring.
- ch0 and ch2 both 12:00:00: match -> ringing=4'b0101, active_ch=0, led alternates 2'b10/2'b01 per blink_tick. dismiss+snooze same cycle -> all IDLE, led=0.
- Ringing ch3, deassert alarm_en[3] -> ringing[3]=0 next cycle. Re-enable at a non-matching time -> stays IDLE.
- Assert rst_n=0 asynchronously mid-SNOOZE -> all outputs 0 immediately; old alarm time no longer matches.
